// File: rtl/uart_rx_deser.sv
// uart_rx_deser: UART receive deserializer, optional parity check enabled by UART_RX_PARITY_EN
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                  CLKip,
  input  logic                  RSTi,
  input  logic                  RXi,
  input  logic                  FULLi,
  output logic [DATA_WIDTH-1:0] DATAo,
  output logic                  VALIDo,
  output logic                  BUSYo,
  output logic                  FRAME_ERRo,
  output logic                  PAR_ERRo,
  output logic                  OVERRUNo
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_RX_PARITY_EN
    , S_PAR
`endif
  } state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PAR;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif
  state_t r_state, w_next;
  logic r_sync1, r_rx, r_rx_prev;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic w_fall, w_tick, w_stop, w_good, w_perr;
  assign w_fall   = r_rx_prev & ~r_rx;
  assign w_tick   = (r_state == S_START) ? (r_cnt == CW'(CLKS_PER_BIT/2 - 1)) : (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_stop   = (r_state == S_STOP) & w_tick;
  assign w_good   = w_stop & r_rx & ~w_perr;
  assign BUSYo    = r_state != S_IDLE;
  assign OVERRUNo = VALIDo & FULLi;
  // two-stage synchronizer plus previous-sample register for falling-edge detection
  always_ff @(posedge CLKip or posedge RSTi)
    if (RSTi) {r_sync1, r_rx, r_rx_prev} <= 3'b111;
    else {r_sync1, r_rx, r_rx_prev} <= {RXi, r_sync1, r_rx};
`ifdef UART_RX_PARITY_EN
  logic r_perr;
  // latch the parity mismatch at the middle of the parity bit
  always_ff @(posedge CLKip or posedge RSTi)
    if (RSTi) r_perr <= 1'b0;
    else if (r_state == S_PAR && w_tick) r_perr <= r_rx ^ (^r_shift) ^ PARITY_ODD;
  assign w_perr = r_perr;
`else
  assign w_perr = 1'b0 & PARITY_ODD;
`endif
  // state register
  always_ff @(posedge CLKip or posedge RSTi)
    if (RSTi) r_state <= S_IDLE;
    else r_state <= w_next;
  // next-state: a start that is high at mid-bit is a glitch and drops back to idle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_fall ? S_START : S_IDLE;
      S_START: if (w_tick) w_next = r_rx ? S_IDLE : S_DATA;
      S_DATA:  if (w_tick && r_idx == BW'(DATA_WIDTH - 1)) w_next = S_AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      S_PAR:   if (w_tick) w_next = S_STOP;
`endif
      S_STOP:  if (w_tick) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // bit timing, LSB-first shift-in, and registered result pulses at the stop sample
  always_ff @(posedge CLKip or posedge RSTi)
    if (RSTi) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      DATAo      <= '0;
      VALIDo     <= 1'b0;
      FRAME_ERRo <= 1'b0;
      PAR_ERRo   <= 1'b0;
    end else begin
      r_cnt      <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      r_idx      <= (r_state != S_DATA) ? '0 : r_idx + BW'(w_tick);
      r_shift    <= (r_state == S_DATA && w_tick) ? {r_rx, r_shift[DATA_WIDTH-1:1]} : r_shift;
      DATAo      <= w_good ? r_shift : DATAo;
      VALIDo     <= w_good;
      FRAME_ERRo <= w_stop & ~r_rx;
      PAR_ERRo   <= w_stop & r_rx & w_perr;
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: randomized frame-level bench for uart_rx_deser
module tb_uart_rx_deser;
  localparam int CPB = 16;
  localparam int DW = 8;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif
  localparam int LAT = 3 + CPB/2 + (NB - 1)*CPB;
  logic clk = 0, rst = 1, rx = 1, full = 0;
  logic [DW-1:0] data;
  logic valid, busy, fe, pe, ov;
  uart_rx_deser #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .PARITY_ODD(PODD)) dut (
    .CLKip(clk), .RSTi(rst), .RXi(rx), .FULLi(full), .DATAo(data), .VALIDo(valid),
    .BUSYo(busy), .FRAME_ERRo(fe), .PAR_ERRo(pe), .OVERRUNo(ov)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0, pcyc = 0, t_fall = 0, lat = 0;
  int ev_v = 0, ev_fe = 0, ev_pe = 0, ev_ov = 0, dbl = 0;
  logic prev_v = 0;
  logic [DW-1:0] held = '0;
  always @(posedge clk) pcyc++;
  always @(negedge clk) begin
    if (valid) begin
      ev_v++;
      lat = pcyc - t_fall;
    end
    if (fe) ev_fe++;
    if (pe) ev_pe++;
    if (ov) ev_ov++;
    if (valid && prev_v) dbl++;
    prev_v = valid;
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic par_of(logic [DW-1:0] d);
    return ^d ^ PODD;
  endfunction
  task automatic put_bit(logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic idle(int n);
    rx = 1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(logic [DW-1:0] d, logic par, logic stopb, logic f);
    int bv, bfe, bpe, bov;
    logic perr, good;
    bv = ev_v; bfe = ev_fe; bpe = ev_pe; bov = ev_ov;
    full = f;
    perr = 0;
`ifdef UART_RX_PARITY_EN
    perr = par != par_of(d);
`endif
    good = stopb && !perr;
    t_fall = pcyc;
    put_bit(0);
    for (int i = 0; i < DW; i++) put_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    put_bit(par);
`endif
    put_bit(stopb);
    chk("valid_cnt", ev_v - bv, 32'(good));
    chk("frame_err_cnt", ev_fe - bfe, 32'(!stopb));
    chk("par_err_cnt", ev_pe - bpe, 32'(stopb && perr));
    chk("overrun_cnt", ev_ov - bov, 32'(good && f));
    if (good) begin
      held = d;
      chk("latency", lat, LAT);
    end
    chk("data", data, held);
    chk("busy_end", busy, 0);
  endtask
  initial begin
    int base;
    logic [DW-1:0] d;
    logic stopb;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fe", fe, 0);
    chk("rst_pe", pe, 0);
    chk("rst_ov", ov, 0);
    rst = 0;
    idle(2*CPB);
    send(8'hA5, par_of(8'hA5), 1, 0);
    idle(CPB);
    send(8'h3C, par_of(8'h3C), 1, 0);
    send(8'hFF, par_of(8'hFF), 1, 0);
    idle(CPB);
    send(8'h55, par_of(8'h55), 0, 0);
    idle(CPB);
    base = ev_v + ev_fe + ev_pe;
    rx = 0;
    repeat (5) @(negedge clk);
    rx = 1;
    repeat (8) @(negedge clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_events", ev_v + ev_fe + ev_pe - base, 0);
    idle(CPB);
    send(8'h81, par_of(8'h81), 1, 1);
    full = 0;
    idle(CPB);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1, 0);
    idle(CPB);
    send(8'h07, 1'b0, 1, 0);
    idle(CPB);
`endif
    base = ev_fe;
    rx = 0;
    repeat (3*NB*CPB) @(negedge clk);
    idle(CPB);
    chk("break_fe", ev_fe - base, 1);
    put_bit(0);
    put_bit(1);
    put_bit(0);
    rst = 1;
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_fe", fe, 0);
    rx = 1;
    @(negedge clk);
    rst = 0;
    held = '0;
    idle(2*CPB);
    repeat (24) begin
      d = DW'($urandom);
      stopb = $urandom_range(0, 4) != 0;
      send(d, par_of(d) ^ ($urandom_range(0, 3) == 0), stopb, 1'($urandom_range(0, 1)));
      full = 0;
      idle(stopb ? $urandom_range(0, 2)*CPB : $urandom_range(1, 2)*CPB);
    end
    chk("valid_back_to_back", dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
